approx_adder_err_monitor: RTL and testbench

- Streaming error-metric checker, the consumer end of our approximate ripple-carry adders (e.g. 16-bit RC with approximated low full-adder cells).
- Accepts operand pairs plus the approximate adder's WIDTH+1-bit sum over a valid/ready handshake.
- Computes the exact sum internally and accumulates, over a programmed number of samples:
  - error count
  - sum of absolute error
  - sum of squared error (MSE numerator)
  - worst-case absolute error, with the operands that produced it
- Used in simulation benches and FPGA characterisation of pwr/MSE trade-offs.

---
 rtl/approx_adder_err_monitor.sv | 144 ++++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
// Streaming error-metric monitor for approximate adders: compares each approximate
// sum against the exact sum and accumulates error count, |e|, e^2 and worst case.
module approx_adder_err_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH:0]     in_approx,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_count,
    output logic [ACC_W-1:0]   sum_abs_err,
    output logic [ACC_W-1:0]   sum_sq_err,
    output logic [WIDTH+1:0]   max_abs_err,
    output logic [WIDTH-1:0]   wce_a,
    output logic [WIDTH-1:0]   wce_b
);

    localparam int DW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [DW-1:0] abs_val(input logic signed [DW-1:0] d);
        return d[DW-1] ? $unsigned(-d) : $unsigned(d);
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] x,
                                                 input logic [ACC_W-1:0] y);
        logic [ACC_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  num_q, cnt_q;
    logic              vld_p1_q, vld_p2_q;
    logic              start_ok, accept, last;

    logic [WIDTH:0]         exact_s;
    logic signed [DW-1:0]   diff_s;
    logic [WIDTH-1:0]       a_p1_q, b_p1_q;
    logic [DW-1:0]          abs_p1_q;
    logic                   ne_p1_q;
    logic [2*DW-1:0]        sq_s;

    logic [CNT_W-1:0]  err_q;
    logic [ACC_W-1:0]  sum_abs_q, sum_sq_q;
    logic [DW-1:0]     max_q;
    logic [WIDTH-1:0]  wce_a_q, wce_b_q;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign in_ready = (state_q == RUN) && (cnt_q < num_q);
    assign accept   = in_valid && in_ready;
    assign last     = accept && (cnt_q == num_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (num_samples == '0) ? DONE : RUN;
            RUN:        if (last) state_d = DRAIN;
            DRAIN:      if (!vld_p1_q && !vld_p2_q) state_d = DONE;
            default:    state_d = IDLE;
        endcase
        // A zero-sample restart from DONE re-enters DONE and must pulse again.
        done_d = (state_d == DONE) && (state_q != DONE || start_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            num_q    <= '0;
            cnt_q    <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            vld_p1_q <= accept;
            vld_p2_q <= vld_p1_q;
            if (start_ok) begin
                num_q <= num_samples;
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage 1: exact sum, signed error, magnitude; operands travel along
    assign exact_s = {1'b0, in_a} + {1'b0, in_b};
    assign diff_s  = $signed({1'b0, in_approx}) - $signed({1'b0, exact_s});

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1_q   <= in_a;
            b_p1_q   <= in_b;
            abs_p1_q <= abs_val(diff_s);
            ne_p1_q  <= (diff_s != '0);
        end
    end

    // Stage 2: accumulate into the result registers
    assign sq_s = (2*DW)'(abs_p1_q) * (2*DW)'(abs_p1_q);

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_q     <= '0;
            sum_abs_q <= '0;
            sum_sq_q  <= '0;
            max_q     <= '0;
            wce_a_q   <= '0;
            wce_b_q   <= '0;
        end else if (vld_p1_q) begin
            err_q     <= err_q + CNT_W'(ne_p1_q);
            sum_abs_q <= sat_add(sum_abs_q, ACC_W'(abs_p1_q));
            sum_sq_q  <= sat_add(sum_sq_q, ACC_W'(sq_s));
            if (abs_p1_q > max_q) begin
                max_q   <= abs_p1_q;
                wce_a_q <= a_p1_q;
                wce_b_q <= b_p1_q;
            end
        end
    end

    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = done_q;
    assign err_count   = err_q;
    assign sum_abs_err = sum_abs_q;
    assign sum_sq_err  = sum_sq_q;
    assign max_abs_err = max_q;
    assign wce_a       = wce_a_q;
    assign wce_b       = wce_b_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Bench for approx_adder_err_monitor: a default instance plus an ACC_W=34 instance
// sharing stimulus; a done-triggered scoreboard compares every run's results.
module tb_approx_adder_err_monitor;

    localparam int W   = 16;
    localparam int CW  = 32;
    localparam int AW  = 48;
    localparam int AWS = 34;

    localparam logic [AW-1:0]  SQ_ONE = 48'd17179344900;
    localparam logic [AW-1:0]  SQ_TWO = 48'd34358689800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, in_valid;
    logic [CW-1:0] num_samples;
    logic [W-1:0]  in_a, in_b;
    logic [W:0]    in_approx;

    logic          in_ready, busy, done;
    logic [CW-1:0] err_count;
    logic [AW-1:0] sum_abs_err, sum_sq_err;
    logic [W+1:0]  max_abs_err;
    logic [W-1:0]  wce_a, wce_b;

    logic           in_ready_s, busy_s, done_s;
    logic [CW-1:0]  err_count_s;
    logic [AWS-1:0] sum_abs_err_s, sum_sq_err_s;
    logic [W+1:0]   max_abs_err_s;
    logic [W-1:0]   wce_a_s, wce_b_s;

    approx_adder_err_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .busy(busy), .done(done), .err_count(err_count),
        .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err), .max_abs_err(max_abs_err),
        .wce_a(wce_a), .wce_b(wce_b)
    );

    approx_adder_err_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AWS)) dut_s (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .busy(busy_s), .done(done_s), .err_count(err_count_s),
        .sum_abs_err(sum_abs_err_s), .sum_sq_err(sum_sq_err_s), .max_abs_err(max_abs_err_s),
        .wce_a(wce_a_s), .wce_b(wce_b_s)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CW-1:0]  err;
        logic [AW-1:0]  sabs;
        logic [AW-1:0]  ssq;
        logic [AWS-1:0] sabs_s;
        logic [AWS-1:0] ssq_s;
        logic [W+1:0]   mx;
        logic [W-1:0]   wa;
        logic [W-1:0]   wb;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    longint m_err, m_abs, m_sq, m_max, m_wa, m_wb;

    function automatic longint sat(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_clear();
        m_err = 0; m_abs = 0; m_sq = 0; m_max = 0; m_wa = 0; m_wb = 0;
    endtask

    task automatic model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W:0] ap);
        longint ex, d, ab;
        ex = longint'(a) + longint'(b);
        d  = longint'(ap) - ex;
        ab = (d < 0) ? -d : d;
        if (d != 0) m_err = m_err + 1;
        m_abs = m_abs + ab;
        m_sq  = m_sq + ab * ab;
        if (ab > m_max) begin
            m_max = ab; m_wa = longint'(a); m_wb = longint'(b);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.err    = CW'(m_err);
        e.sabs   = AW'(sat(m_abs, AW));
        e.ssq    = AW'(sat(m_sq, AW));
        e.sabs_s = AWS'(sat(m_abs, AWS));
        e.ssq_s  = AWS'(sat(m_sq, AWS));
        e.mx     = (W+2)'(m_max);
        e.wa     = W'(m_wa);
        e.wb     = W'(m_wb);
        exp_q.push_back(e);
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got done=1 required no pending run");
            end else begin
                mon_e = exp_q.pop_front();
                if (err_count !== mon_e.err) begin
                    errors++; $display("FAIL sb_err_count: got %0d required %0d", err_count, mon_e.err);
                end
                checks++;
                if (sum_abs_err !== mon_e.sabs) begin
                    errors++; $display("FAIL sb_sum_abs: got %0d required %0d", sum_abs_err, mon_e.sabs);
                end
                checks++;
                if (sum_sq_err !== mon_e.ssq) begin
                    errors++; $display("FAIL sb_sum_sq: got %0d required %0d", sum_sq_err, mon_e.ssq);
                end
                checks++;
                if (max_abs_err !== mon_e.mx) begin
                    errors++; $display("FAIL sb_max_abs: got %0d required %0d", max_abs_err, mon_e.mx);
                end
                checks++;
                if ({wce_a, wce_b} !== {mon_e.wa, mon_e.wb}) begin
                    errors++;
                    $display("FAIL sb_wce: got a=%0d b=%0d required a=%0d b=%0d",
                             wce_a, wce_b, mon_e.wa, mon_e.wb);
                end
                checks++;
                if ({done_s, sum_abs_err_s, sum_sq_err_s} !== {1'b1, mon_e.sabs_s, mon_e.ssq_s}) begin
                    errors++;
                    $display("FAIL sb_acc34: got done=%0d abs=%0d sq=%0d required done=1 abs=%0d sq=%0d",
                             done_s, sum_abs_err_s, sum_sq_err_s, mon_e.sabs_s, mon_e.ssq_s);
                end
            end
        end
    end

    task automatic pulse_start(input logic [CW-1:0] n);
        start = 1'b1;
        num_samples = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] ap, output bit ok);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_approx = ap;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_add(a, b, ap);
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ok = acc;
    endtask

    task automatic wait_done(output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && !ok; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                lat = i;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        bit seen;
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({in_ready, busy, done, err_count, sum_abs_err, sum_sq_err, max_abs_err, wce_a, wce_b} !== '0) begin
            errors++; $display("FAIL reset_state: got outputs not all zero (busy=%0d ready=%0d) required 0", busy, in_ready);
        end
        model_clear();
        pulse_start(5);
        send(16'd1, 16'd1, 17'd0, ok);
        send(16'd9, 16'd0, 17'd1, ok);
        send(16'd4, 16'd4, 17'd2, ok);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_pre_busy: got %0d required 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, busy, done, err_count, sum_abs_err, sum_sq_err, max_abs_err, wce_a, wce_b} !== '0) begin
            errors++;
            $display("FAIL reset_midrun: got busy=%0d ready=%0d done=%0d err=%0d abs=%0d required all 0",
                     busy, in_ready, done, err_count, sum_abs_err);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL reset_no_done: got done/busy activity=1 required 0");
        end
        model_clear();
        pulse_start(1);
        send(16'd2, 16'd3, 17'd4, ok);
        push_exp();
        wait_done(lat, ok);
        checks++;
        if (!ok || err_count !== 32'd1 || sum_abs_err !== 48'd1) begin
            errors++; $display("FAIL reset_rerun: got done=%0d err=%0d abs=%0d required 1 1 1", ok, err_count, sum_abs_err);
        end
    endtask

    task automatic test_exact();
        bit ok;
        int lat;
        model_clear();
        pulse_start(4);
        send(16'd3, 16'd5, 17'd8, ok);
        send(16'd0, 16'd0, 17'd0, ok);
        send(16'd65535, 16'd1, 17'd65536, ok);
        send(16'd100, 16'd27, 17'd127, ok);
        push_exp();
        wait_done(lat, ok);
        checks++;
        if (!ok || lat != 3) begin
            errors++; $display("FAIL exact_latency: got ok=%0d cycles=%0d required 3", ok, lat);
        end
        checks++;
        if ({err_count, sum_abs_err, sum_sq_err, max_abs_err, wce_a, wce_b} !== '0) begin
            errors++; $display("FAIL exact_results: got err=%0d abs=%0d sq=%0d max=%0d required all 0",
                               err_count, sum_abs_err, sum_sq_err, max_abs_err);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL exact_done_pulse: got %0d required 0", done);
        end
    endtask

    task automatic test_errors();
        bit ok;
        int lat;
        model_clear();
        pulse_start(3);
        send(16'd3, 16'd5, 17'd6, ok);
        send(16'd10, 16'd10, 17'd24, ok);
        send(16'd7, 16'd1, 17'd4, ok);
        push_exp();
        wait_done(lat, ok);
        checks++;
        if (!ok || err_count !== 32'd3 || sum_abs_err !== 48'd10 || sum_sq_err !== 48'd36) begin
            errors++; $display("FAIL errors_sums: got err=%0d abs=%0d sq=%0d required 3 10 36",
                               err_count, sum_abs_err, sum_sq_err);
        end
        checks++;
        if (max_abs_err !== 18'd4 || wce_a !== 16'd10 || wce_b !== 16'd10) begin
            errors++; $display("FAIL errors_wce: got max=%0d a=%0d b=%0d required 4 10 10",
                               max_abs_err, wce_a, wce_b);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sum_abs_err !== 48'd10 || max_abs_err !== 18'd4) begin
            errors++; $display("FAIL errors_hold: got abs=%0d max=%0d required 10 4", sum_abs_err, max_abs_err);
        end
    endtask

    task automatic test_handshake();
        bit ok;
        int lat;
        int nacc;
        bit          pat[4];
        logic [W-1:0] sa[4];
        logic [W-1:0] sb[4];
        logic [W:0]   sp[4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        sa  = '{16'd1, 16'd50, 16'd5, 16'd9};
        sb  = '{16'd2, 16'd50, 16'd5, 16'd9};
        sp  = '{17'd4, 17'd0, 17'd9, 17'd0};
        nacc = 0;
        model_clear();
        pulse_start(2);
        for (int i = 0; i < 4; i++) begin
            in_valid = pat[i]; in_a = sa[i]; in_b = sb[i]; in_approx = sp[i];
            @(negedge clk);
            if (in_valid && in_ready === 1'b1) begin
                model_add(sa[i], sb[i], sp[i]);
                nacc++;
            end
            if (i == 3) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL hs_ready_low: got %0d required 0", in_ready);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (nacc != 2) begin
            errors++; $display("FAIL hs_accept_count: got %0d required 2", nacc);
        end
        push_exp();
        wait_done(lat, ok);
        checks++;
        if (!ok || err_count !== 32'd2 || sum_abs_err !== 48'd2 || max_abs_err !== 18'd1 || wce_a !== 16'd1) begin
            errors++; $display("FAIL hs_results: got err=%0d abs=%0d max=%0d wa=%0d required 2 2 1 1",
                               err_count, sum_abs_err, max_abs_err, wce_a);
        end
    endtask

    task automatic test_zero_and_busy();
        bit ok;
        int lat;
        model_clear();
        push_exp();
        pulse_start(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done=%0d busy=%0d required 1 0", done, busy);
        end
        checks++;
        if ({err_count, sum_abs_err, sum_sq_err, max_abs_err, wce_a, wce_b} !== '0) begin
            errors++; $display("FAIL zero_results: got err=%0d abs=%0d required 0 0", err_count, sum_abs_err);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_after: got done=%0d busy=%0d required 0 0", done, busy);
        end
        model_clear();
        pulse_start(2);
        send(16'd20, 16'd30, 17'd40, ok);
        pulse_start(0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL busy_start_ignored: got busy=%0d done=%0d required 1 0", busy, done);
        end
        send(16'd1, 16'd1, 17'd5, ok);
        push_exp();
        wait_done(lat, ok);
        checks++;
        if (!ok || err_count !== 32'd2 || sum_abs_err !== 48'd13 || sum_sq_err !== 48'd109) begin
            errors++; $display("FAIL busy_results: got err=%0d abs=%0d sq=%0d required 2 13 109",
                               err_count, sum_abs_err, sum_sq_err);
        end
    endtask

    task automatic test_extreme();
        bit ok;
        int lat;
        logic [AWS-1:0] ones_s;
        ones_s = '1;
        model_clear();
        pulse_start(1);
        send(16'hFFFF, 16'hFFFF, 17'd0, ok);
        push_exp();
        wait_done(lat, ok);
        checks++;
        if (!ok || max_abs_err !== 18'd131070 || sum_sq_err !== SQ_ONE || sum_abs_err !== 48'd131070) begin
            errors++; $display("FAIL extreme_single: got max=%0d sq=%0d abs=%0d required 131070 %0d 131070",
                               max_abs_err, sum_sq_err, sum_abs_err, SQ_ONE);
        end
        checks++;
        if (sum_sq_err_s !== AWS'(SQ_ONE) || wce_a !== 16'hFFFF || wce_b !== 16'hFFFF) begin
            errors++; $display("FAIL extreme_single34: got sq=%0d a=%0d b=%0d required %0d 65535 65535",
                               sum_sq_err_s, wce_a, wce_b, SQ_ONE);
        end
        model_clear();
        pulse_start(2);
        send(16'hFFFF, 16'hFFFF, 17'd0, ok);
        send(16'hFFFF, 16'hFFFF, 17'd0, ok);
        push_exp();
        wait_done(lat, ok);
        checks++;
        if (!ok || sum_sq_err !== SQ_TWO) begin
            errors++; $display("FAIL extreme_sq48: got %0d required %0d", sum_sq_err, SQ_TWO);
        end
        checks++;
        if (sum_sq_err_s !== ones_s || sum_abs_err_s !== 34'd262140) begin
            errors++; $display("FAIL extreme_sat34: got sq=%0d abs=%0d required %0d 262140",
                               sum_sq_err_s, sum_abs_err_s, ones_s);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_approx = '0;
        test_reset();
        test_exact();
        test_errors();
        test_handshake();
        test_zero_and_busy();
        test_extreme();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_pending: got %0d unconsumed results required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
